// File: rtl/bcd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bcd_pkg                                                    |
// | Description : Shared types and constants for the single-digit BCD adder. |
// |               digit_t  - one 4-bit BCD digit                             |
// |               BCD_MAX  - largest legal BCD digit value (9)               |
// |               BCD_CORR - decimal correction added when sum exceeds 9     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package bcd_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t BCD_MAX  = 4'd9;
  localparam digit_t BCD_CORR = 4'd6;

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_fadd_1digit_fadd4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fadd4                                                      |
// | Description : Purely combinational 4-bit binary adder with carry in and  |
// |               carry out. Together {cout, s} is the full 5-bit sum.       |
// | Ports       : a, b  - 4-bit addends                                      |
// |               cin   - carry in                                           |
// |               s     - low 4 bits of a + b + cin                          |
// |               cout  - bit 4 of a + b + cin                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fadd4
  import bcd_pkg::*;
(
  input  digit_t a,
  input  digit_t b,
  input  logic   cin,
  output digit_t s,
  output logic   cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule : fadd4
`default_nettype wire

// File: rtl/bcd_fadd_1digit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bcd_fadd_1digit                                            |
// | Description : One-digit BCD full adder. Binary sum from fadd4, then the  |
// |               +6 decimal correction when the sum exceeds 9, registered   |
// |               at the output. IN_REG=1 adds an input stage (latency 2),   |
// |               IN_REG=0 gives latency 1. No backpressure.                 |
// | Config      : `define BCD_INPUT_CHECK_EN flags non-BCD inputs (>9) on    |
// |               err and forces sum/cout to 0; otherwise err is tied to 0.  |
// | Ports       : clk, rst (async, active-high)                              |
// |               in_valid, a, b, cin      - operand digits and carry in     |
// |               out_valid, sum, cout, err - result; sum/cout/err hold      |
// |                                          their values while idle         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module bcd_fadd_1digit
  import bcd_pkg::*;
#(
  parameter int IN_REG = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic       out_valid,
  output logic [3:0] sum,
  output logic       cout,
  output logic       err
);

  // Operands as seen by the adder (either raw ports or the input stage)
  digit_t w_a;
  digit_t w_b;
  logic   w_cin;
  logic   w_v;

  generate
    if (IN_REG != 0) begin : g_in_reg
      digit_t r_a;
      digit_t r_b;
      logic   r_cin;
      logic   r_v;

      // Operand registers load only on a valid beat; the valid bit
      // follows in_valid every cycle so bubbles propagate.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a   <= '0;
          r_b   <= '0;
          r_cin <= 1'b0;
          r_v   <= 1'b0;
        end else begin
          r_v <= in_valid;
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_cin <= cin;
          end
        end
      end

      assign w_a   = r_a;
      assign w_b   = r_b;
      assign w_cin = r_cin;
      assign w_v   = r_v;
    end else begin : g_no_in_reg
      assign w_a   = a;
      assign w_b   = b;
      assign w_cin = cin;
      assign w_v   = in_valid;
    end
  endgenerate

  // Binary sum 0..31
  digit_t w_s;
  logic   w_co;

  fadd4 u_fadd4 (
    .a    (w_a),
    .b    (w_b),
    .cin  (w_cin),
    .s    (w_s),
    .cout (w_co)
  );

  logic       w_over;
  digit_t     w_sum_corr;
  logic       w_bad;
  digit_t     w_nxt_sum;
  logic       w_nxt_cout;

  // Decimal overflow when the 5-bit sum is 10 or more. Adding 6 to the
  // low nibble is the same as (s+6)[3:0] since bit 4 is discarded anyway.
  assign w_over     = ({w_co, w_s} > {1'b0, BCD_MAX});
  assign w_sum_corr = w_s + BCD_CORR;

`ifdef BCD_INPUT_CHECK_EN
  assign w_bad = (w_a > BCD_MAX) || (w_b > BCD_MAX);
`else
  assign w_bad = 1'b0;
`endif

  assign w_nxt_sum  = w_bad ? 4'd0 : (w_over ? w_sum_corr : w_s);
  assign w_nxt_cout = ~w_bad & w_over;

  logic   r_out_valid;
  digit_t r_sum;
  logic   r_cout;
  logic   r_err;

  // Result registers update only on a valid beat and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= w_v;
      if (w_v) begin
        r_sum  <= w_nxt_sum;
        r_cout <= w_nxt_cout;
        r_err  <= w_bad;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign err       = r_err;

endmodule : bcd_fadd_1digit
`default_nettype wire

// File: tb/tb_bcd_fadd_1digit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_bcd_fadd_1digit                                         |
// | Description : Self-checking bench for bcd_fadd_1digit. Two instances     |
// |               share stimulus: u_dut0 (IN_REG=0) and u_dut1 (IN_REG=1).   |
// |               Honours `define BCD_INPUT_CHECK_EN for err expectations.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_bcd_fadd_1digit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;

  logic       ov0, co0, er0;
  logic [3:0] sm0;
  logic       ov1, co1, er1;
  logic [3:0] sm1;

  int total;
  int bad;

  bcd_fadd_1digit #(.IN_REG(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .out_valid(ov0), .sum(sm0), .cout(co0), .err(er0)
  );

  bcd_fadd_1digit #(.IN_REG(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .out_valid(ov1), .sum(sm1), .cout(co1), .err(er1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       err;
  } vec_t;

  vec_t tbl[8];

  // Packed view {out_valid, err, cout, sum}
  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got v/e/c/s=%b/%b/%b/%0d want %b/%b/%b/%0d",
               name, act[6], act[5], act[4], act[3:0], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  // Reference: decimal addition rules, returns {err, cout, sum}
  function automatic logic [5:0] model(input logic [3:0] x, input logic [3:0] y, input logic c);
    int s;
`ifdef BCD_INPUT_CHECK_EN
    if (x > 4'd9 || y > 4'd9) return 6'b100000;
`endif
    s = int'(x) + int'(y) + int'(c);
    if (s <= 9) return {2'b00, 4'(s)};
    return {2'b01, 4'((s + 6) % 16)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] x, input logic [3:0] y, input logic c);
    in_valid = v;
    a        = x;
    b        = y;
    cin      = c;
  endtask

  logic [5:0] e0, e1, pend_e;
  logic       pend_v;
  logic       rv;
  logic [3:0] ra, rb;
  logic       rc;
  int         s;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(1'b0, 4'd0, 4'd0, 1'b0);

    // Reset state
    #1;
    chk("reset0", {ov0, er0, co0, sm0}, 7'd0);
    chk("reset1", {ov1, er1, co1, sm1}, 7'd0);
    step();
    chk("reset0_clk", {ov0, er0, co0, sm0}, 7'd0);
    rst = 1'b0;
    step();

    // Exhaustive legal-digit sweep, IN_REG=0, back to back
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++)
        for (int k = 0; k < 2; k++) begin
          drive(1'b1, 4'(i), 4'(j), 1'(k));
          step();
          s = i + j + k;
          chk("sweep", {ov0, er0, co0, sm0}, {1'b1, 1'b0, (s >= 10), 4'(s % 10)});
        end

    // Directed table
    tbl[0] = '{4'd5, 4'd5, 1'b0, 4'd0, 1'b1, 1'b0};
    tbl[1] = '{4'd7, 4'd8, 1'b1, 4'd6, 1'b1, 1'b0};
    tbl[2] = '{4'd4, 4'd5, 1'b0, 4'd9, 1'b0, 1'b0};
    tbl[3] = '{4'd9, 4'd9, 1'b1, 4'd9, 1'b1, 1'b0};
    tbl[4] = '{4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[5] = '{4'd4, 4'd5, 1'b1, 4'd0, 1'b1, 1'b0};
`ifdef BCD_INPUT_CHECK_EN
    tbl[6] = '{4'd12, 4'd3,  1'b0, 4'd0, 1'b0, 1'b1};
    tbl[7] = '{4'd15, 4'd15, 1'b1, 4'd0, 1'b0, 1'b1};
`else
    tbl[6] = '{4'd12, 4'd3,  1'b0, 4'd5, 1'b1, 1'b0};
    tbl[7] = '{4'd15, 4'd15, 1'b1, 4'd5, 1'b1, 1'b0};
`endif
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin);
      step();
      chk($sformatf("tbl%0d", i), {ov0, er0, co0, sm0},
          {1'b1, tbl[i].err, tbl[i].cout, tbl[i].sum});
    end

    // 9+9+1 then idle: results hold, only out_valid drops
    drive(1'b1, 4'd9, 4'd9, 1'b1);
    step();
    chk("hold_load", {ov0, er0, co0, sm0}, {1'b1, 1'b0, 1'b1, 4'd9});
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'(i + 1), 4'd2, 1'b0);
      step();
      chk("hold_idle0", {ov0, er0, co0, sm0}, {1'b0, 1'b0, 1'b1, 4'd9});
    end
    chk("hold_idle1", {ov1, er1, co1, sm1}, {1'b0, 1'b0, 1'b1, 4'd9});

    // Async reset mid-flight with IN_REG=1 holding an operation
    drive(1'b1, 4'd3, 4'd4, 1'b0);
    step();
    chk("pre_rst0", {ov0, er0, co0, sm0}, {1'b1, 1'b0, 1'b0, 4'd7});
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst0", {ov0, er0, co0, sm0}, 7'd0);
    chk("async_rst1", {ov1, er1, co1, sm1}, 7'd0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_stale1", {ov1, er1, co1, sm1}, 7'd0);
    end

    // IN_REG=1 back-to-back
    drive(1'b1, 4'd1, 4'd2, 1'b0);
    step();
    chk("b2b_lat", {ov1, er1, co1, sm1}, 7'd0);
    drive(1'b1, 4'd6, 4'd6, 1'b1);
    step();
    chk("b2b_first", {ov1, er1, co1, sm1}, {1'b1, 1'b0, 1'b0, 4'd3});
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    step();
    chk("b2b_second", {ov1, er1, co1, sm1}, {1'b1, 1'b0, 1'b1, 4'd3});
    step();
    chk("b2b_idle", {ov1, er1, co1, sm1}, {1'b0, 1'b0, 1'b1, 4'd3});

    // Random stream against the scoreboard, both latencies
    rst = 1'b1;
    #1;
    rst = 1'b0;
    e0     = '0;
    e1     = '0;
    pend_e = '0;
    pend_v = 1'b0;
    for (int n = 0; n < 400; n++) begin
      rv = ($urandom_range(0, 3) != 0);
      ra = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      rb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      rc = 1'($urandom_range(0, 1));
      drive(rv, ra, rb, rc);
      step();
      if (pend_v) e1 = pend_e;
      if (rv) e0 = model(ra, rb, rc);
      chk("rand0", {ov0, er0, co0, sm0}, {rv, e0});
      chk("rand1", {ov1, er1, co1, sm1}, {pend_v, e1});
      pend_v = rv;
      if (rv) pend_e = model(ra, rb, rc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bcd_fadd_1digit
`default_nettype wire
